// File: rtl/mem_bus_arbiter.sv
// Two-master front end for a fixed-latency memory port: req/ack handshake, round-robin
// arbitration with a capped lock, and an address -> wait -> response access sequence.
module mem_bus_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int LOCK_MAX    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_lock,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_write_enable,
  output logic [1:0]  mem_data_size,
  input  logic [31:0] mem_data_in,
  output logic        grant_id,
  output logic        busy
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [LW-1:0] LOCK_LIMIT = LW'(LOCK_MAX);
  localparam logic [LW-1:0] LOCK_ONE   = LW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             last_grant;
  logic             prev_lock;
  logic [LW-1:0]    lock_cnt;

  logic [1:0]       req;
  logic [1:0][31:0] addr_v;
  logic [1:0][31:0] wdata_v;
  logic [1:0][1:0]  size_v;
  logic [1:0]       we_v;
  logic [1:0]       lock_v;
  logic             win;
  logic             lock_hit;

  assign req     = {m1_req, m0_req};
  assign addr_v  = {m1_addr, m0_addr};
  assign wdata_v = {m1_wdata, m0_wdata};
  assign size_v  = {m1_size, m0_size};
  assign we_v    = {m1_we, m0_we};
  assign lock_v  = {m1_lock, m0_lock};
  assign busy    = (state != S_IDLE);

  // A locked owner keeps the port until LOCK_MAX extra grants; then one round-robin decision.
  always_comb begin
    lock_hit = prev_lock && req[last_grant] && (lock_cnt < LOCK_LIMIT);
    if (lock_hit)     win = last_grant;
    else if (&req)    win = ~last_grant;
    else              win = req[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      last_grant       <= 1'b1;
      prev_lock        <= 1'b0;
      lock_cnt         <= '0;
      mem_address      <= '0;
      mem_data_out     <= '0;
      mem_write_enable <= 1'b0;
      mem_data_size    <= 2'b10;
      grant_id         <= 1'b0;
      m0_ack           <= 1'b0;
      m1_ack           <= 1'b0;
      m0_rdata         <= '0;
      m1_rdata         <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            mem_address      <= addr_v[win];
            mem_data_out     <= wdata_v[win];
            mem_write_enable <= we_v[win];
            mem_data_size    <= size_v[win];
            grant_id         <= win;
            last_grant       <= win;
            prev_lock        <= lock_v[win];
            lock_cnt         <= lock_hit ? lock_cnt + LOCK_ONE : '0;
            cnt              <= CNT_INIT;
            state            <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            // write enable still reflects the access type here; reads capture data
            if (!mem_write_enable) begin
              if (grant_id) m1_rdata <= mem_data_in;
              else          m0_rdata <= mem_data_in;
            end
            if (grant_id) m1_ack <= 1'b1;
            else          m0_ack <= 1'b1;
            mem_write_enable <= 1'b0;
            state            <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
